fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
//  Read-side consumer for the dual-clock FIFO. Runs entirely in the read clock domain.
//  Pops the FIFO's first-word-fall-through read port (data valid whenever !empty).
//  Re-presents words as a registered valid/ready stream through a 2-entry skid buffer.
//  Tags every BURST_LEN-th word with m_last; a flush command drains and discards FIFO contents.
// PARAMETERS
//  WIDTH        32  data word width; equals the FIFO WIDTH
//  BURST_LEN    8   words per burst; m_last marks word BURST_LEN-1; must be >= 2
//  CNT_W        3   burst counter width; must satisfy 2**CNT_W >= BURST_LEN
//  FLUSH_QUIET  4   consecutive fifo_empty cycles that end a flush; covers the 2-stage pointer sync
// PORTS
//  rd_clk      in   1      read-domain clock
//  rd_reset    in   1      synchronous, active-high reset
//  fifo_data   in   WIDTH  FIFO data_out; valid when fifo_empty=0
//  fifo_empty  in   1      FIFO empty flag
//  fifo_rd_en  out  1      FIFO pop strobe; combinational
//  m_data      out  WIDTH  stream data; registered
//  m_valid     out  1      stream valid; registered
//  m_ready     in   1      stream ready from the downstream block
//  m_last      out  1      last word of the burst; qualified by m_valid
//  flush_req   in   1      one-cycle pulse; starts a flush
//  flush_busy  out  1      high while state=FLUSH
//  drop_cnt    out  16     count of words discarded by flushes; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rd_reset=1 at a rd_clk edge):
//   - state=STREAM, skid count=0, pop_cnt=0.
//   - m_valid=0, m_data=0, m_last=0, flush_busy=0, drop_cnt=0.
//   - fifo_rd_en is forced 0 while rd_reset=1.
//   - Reset mid-burst or mid-flush discards buffered words; nothing is popped during reset.
//  Skid buffer: entries OUT (drives m_*) and SKID; cnt in 0..2; each entry holds {last, data}.
//  STREAM state:
//   - fifo_rd_en = !fifo_empty && cnt!=2.
//   - A popped word is tagged last = (pop_cnt==BURST_LEN-1).
//   - pop_cnt increments per pop and wraps to 0 after BURST_LEN-1.
//   - Transfer = m_valid && m_ready.
//   - Pop into an empty OUT: m_valid=1 on the next cycle. Latency FIFO->m_valid is 1 cycle.
//   - Transfer with SKID full: SKID moves to OUT; a simultaneous pop fills SKID.
//   - Pop with OUT holding and no transfer: the word goes to SKID.
//   - Steady state with m_ready=1: one word per cycle, no bubbles.
//   - m_valid=1 && m_ready=0: m_data and m_last hold stable; order is strictly FIFO.
//  FLUSH state:
//   - Entered on flush_req from STREAM. Next cycle: cnt=0, m_valid=0, pop_cnt=0.
//   - A transfer in the flush_req cycle completes normally; untransferred buffered words count as dropped.
//   - fifo_rd_en = !fifo_empty. Each pop increments drop_cnt (saturating); m_valid stays 0.
//   - quiet counter: increments on fifo_empty=1, clears on fifo_empty=0.
//   - Return to STREAM when the quiet counter reaches FLUSH_QUIET; flush_busy falls that cycle.
//   - flush_req during FLUSH restarts the quiet counter.
//  Simultaneous events:
//   - flush_req wins over a pop in the same cycle; that pop is counted as dropped.
//   - drop_cnt at 16'hFFFF stays at 16'hFFFF.
//   - fifo_empty rising while cnt>0: buffered words still drain normally.
// STRUCTURE
//  Shared package fifo_pkg holds:
//   - state localparams ST_STREAM=1'b0, ST_FLUSH=1'b1
//   - a clog2 function (checks CNT_W against BURST_LEN)
//   - DROP_W=16
//  Sub-module skid_buf2 (WIDTH+1 bits wide): 2-entry skid buffer with push, pop, clear, cnt.
//  Top level holds the FSM, pop_cnt, quiet counter and drop_cnt.
// TESTING
//  1. Burst stream: 16 words 0..15, m_ready=1.
//     -> m_valid 1 cycle after first !fifo_empty; back-to-back 0..15; m_last on 7 and 15.
//  2. Backpressure: m_ready=0 for 5 cycles mid-stream.
//     -> fifo_rd_en drops at cnt=2; m_data holds; no loss or duplication; order preserved.
//  3. Flush with load: 6 words queued, 2 in the buffer, flush_req.
//     -> m_valid=0 next cycle; drop_cnt=6; flush_busy low after 4 quiet cycles; pop_cnt restarts at 0.
//  4. flush_req with a transfer in the same cycle.
//     -> that word is delivered; remaining buffered and FIFO words are counted as dropped.
//  5. Reset mid-burst (after word 3).
//     -> all outputs return to reset values; the next word is tagged as burst position 0.
//  6. Random m_ready at 50%, 1000 words, scoreboarded.
//     -> exact order; m_last exactly every 8th transfer.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side stream.
// Holds the consumer state encoding and the counter sizing helper.
package fifo_pkg;

  typedef enum logic {
    ST_STREAM = 1'b0,
    ST_FLUSH  = 1'b1
  } state_e;

  localparam int DROP_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_skid.sv
// Two-entry skid buffer: OUT drives the stream, SKID absorbs one
// word while the consumer stalls.
module skid_buf2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic [1:0]   cnt
);

  logic [W-1:0] r_out;
  logic [W-1:0] r_skid;
  logic [1:0]   r_cnt;
  logic         r_valid;

  logic [W-1:0] w_out_nxt;
  logic [W-1:0] w_skid_nxt;
  logic [1:0]   w_cnt_nxt;

  always_comb begin
    w_out_nxt  = r_out;
    w_skid_nxt = r_skid;
    w_cnt_nxt  = r_cnt;
    unique case (r_cnt)
      2'd0: begin
        if (push) begin
          w_out_nxt = push_data;
          w_cnt_nxt = 2'd1;
        end
      end
      2'd1: begin
        if (pop && push) begin
          w_out_nxt = push_data;
        end else if (pop) begin
          w_cnt_nxt = 2'd0;
        end else if (push) begin
          w_skid_nxt = push_data;
          w_cnt_nxt  = 2'd2;
        end
      end
      2'd2: begin
        // SKID is older than anything arriving now
        if (pop) begin
          w_out_nxt = r_skid;
          if (push) w_skid_nxt = push_data;
          else      w_cnt_nxt  = 2'd1;
        end
      end
      default: begin
        w_cnt_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_skid  <= '0;
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
    end else if (clr) begin
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_out   <= w_out_nxt;
      r_skid  <= w_skid_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != 2'd0);
    end
  end

  assign out_data  = r_out;
  assign out_valid = r_valid;
  assign cnt       = r_cnt;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer: pops a FWFT FIFO into a registered stream,
// tags burst ends, and drains the FIFO on a flush command.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int BURST_LEN   = 8,
  parameter int CNT_W       = 3,
  parameter int FLUSH_QUIET = 4
) (
  input  logic              rd_clk,
  input  logic              rd_reset,
  input  logic [WIDTH-1:0]  fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int QW = clog2(FLUSH_QUIET + 1);
  localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(BURST_LEN - 1);
  localparam logic [QW-1:0]    QUIET_END = QW'(FLUSH_QUIET - 1);

  generate
    if (BURST_LEN < 2 || clog2(BURST_LEN) > CNT_W || FLUSH_QUIET < 1) begin : g_bad_cfg
      $error("fifo_rd_stream: invalid BURST_LEN/CNT_W/FLUSH_QUIET");
    end
  endgenerate

  state_e            r_state;
  logic [CNT_W-1:0]  r_pop_cnt;
  logic [QW-1:0]     r_quiet;
  logic [DROP_W-1:0] r_drop;

  logic              w_flushing;
  logic              w_pop;
  logic              w_push;
  logic              w_xfer;
  logic [1:0]        w_cnt;
  logic              w_valid;
  logic [WIDTH:0]    w_out;
  logic [2:0]        w_drop_inc;
  logic [DROP_W:0]   w_drop_sum;

  assign w_flushing = (r_state == ST_FLUSH);
  assign w_xfer     = w_valid && m_ready;
  assign w_push     = w_pop && !w_flushing && !flush_req;

  always_comb begin
    w_pop = 1'b0;
    if (!rd_reset) begin
      unique case (r_state)
        ST_FLUSH:  w_pop = !fifo_empty;
        default:   w_pop = !fifo_empty && (w_cnt != 2'd2);
      endcase
    end
  end

  // Entering flush drops whatever the consumer did not take this cycle
  always_comb begin
    w_drop_inc = 3'd0;
    if (w_flushing) begin
      w_drop_inc = {2'b00, w_pop};
    end else if (flush_req) begin
      w_drop_inc = {1'b0, w_cnt} - {2'b00, w_xfer} + {2'b00, w_pop};
    end
  end

  assign w_drop_sum = {1'b0, r_drop} + (DROP_W + 1)'(w_drop_inc);

  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      r_state   <= ST_STREAM;
      r_pop_cnt <= '0;
      r_quiet   <= '0;
      r_drop    <= '0;
    end else begin
      r_drop <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
      if (flush_req) begin
        r_state   <= ST_FLUSH;
        r_quiet   <= '0;
        r_pop_cnt <= '0;
      end else if (w_flushing) begin
        if (!fifo_empty) begin
          r_quiet <= '0;
        end else if (r_quiet == QUIET_END) begin
          r_state <= ST_STREAM;
          r_quiet <= '0;
        end else begin
          r_quiet <= r_quiet + 1'b1;
        end
      end else if (w_push) begin
        r_pop_cnt <= (r_pop_cnt == LAST_POS) ? '0 : r_pop_cnt + 1'b1;
      end
    end
  end

  skid_buf2 #(
    .W (WIDTH + 1)
  ) u_skid (
    .clk       (rd_clk),
    .rst       (rd_reset),
    .clr       (flush_req),
    .push      (w_push),
    .push_data ({(r_pop_cnt == LAST_POS), fifo_data}),
    .pop       (w_xfer),
    .out_data  (w_out),
    .out_valid (w_valid),
    .cnt       (w_cnt)
  );

  assign fifo_rd_en = w_pop;
  assign m_data     = w_out[WIDTH-1:0];
  assign m_last     = w_out[WIDTH];
  assign m_valid    = w_valid;
  assign flush_busy = w_flushing;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and randomized bench for fifo_rd_stream with a FIFO
// model and an ordered scoreboard of expected stream words.
module tb_fifo_rd_stream;

  logic        rd_clk = 1'b0;
  logic        rd_reset;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        flush_req;
  logic        flush_busy;
  logic [15:0] drop_cnt;

  fifo_rd_stream #(
    .WIDTH       (32),
    .BURST_LEN   (8),
    .CNT_W       (3),
    .FLUSH_QUIET (4)
  ) dut (
    .rd_clk     (rd_clk),
    .rd_reset   (rd_reset),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  logic [31:0] fq[$];
  logic [32:0] exq[$];
  int mpos, mquiet, mdrop;
  bit mbusy;
  int n_chk, n_err;
  int xfers, lasts;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] req);
    n_chk++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 32'h0 : fq[0];
  endtask

  task automatic push_word(input logic [31:0] w);
    fq.push_back(w);
    refresh();
  endtask

  // One clock: check outputs at the falling edge, then apply the
  // spec-level effects of the rising edge to the models.
  task automatic step();
    bit pop, xf, fe;
    logic [31:0] w;
    int n;
    @(negedge rd_clk);
    fe = fifo_empty;
    if (rd_reset)   chk("rd_en", fifo_rd_en, 0);
    else if (mbusy) chk("rd_en", fifo_rd_en, !fe);
    else            chk("rd_en", fifo_rd_en, !fe && exq.size() < 2);
    chk("m_valid", m_valid, !mbusy && exq.size() != 0);
    chk("flush_busy", flush_busy, mbusy);
    chk("drop_cnt", drop_cnt, mdrop);
    if (m_valid && exq.size() != 0) begin
      chk("m_data", m_data, exq[0][31:0]);
      chk("m_last", m_last, exq[0][32]);
    end
    pop = fifo_rd_en;
    xf  = m_valid && m_ready;
    @(posedge rd_clk);
    #1;
    if (rd_reset) begin
      exq.delete();
      mpos = 0; mquiet = 0; mdrop = 0; mbusy = 0;
    end else begin
      w = 32'h0;
      if (pop && fq.size() != 0) w = fq.pop_front();
      if (xf && exq.size() != 0) begin
        xfers++;
        if (exq[0][32]) lasts++;
        void'(exq.pop_front());
      end
      if (flush_req) begin
        n = mdrop + exq.size() + int'(pop);
        mdrop = (n > 65535) ? 65535 : n;
        exq.delete();
        mbusy = 1; mquiet = 0; mpos = 0;
      end else if (mbusy) begin
        if (pop) mdrop = (mdrop == 65535) ? 65535 : mdrop + 1;
        mquiet = fe ? mquiet + 1 : 0;
        if (mquiet == 4) begin mbusy = 0; mquiet = 0; end
      end else if (pop) begin
        exq.push_back({(mpos == 7), w});
        mpos = (mpos + 1) % 8;
      end
    end
    refresh();
  endtask

  initial begin
    int x0, l0, d0, pushed;
    rd_reset = 1'b1; flush_req = 1'b0; m_ready = 1'b0;
    refresh();
    step(); step();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", flush_busy, 0);
    chk("rst_drop", drop_cnt, 0);
    rd_reset = 1'b0;

    // burst stream
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(i);
    step();
    chk("t1_latency", m_valid, 1);
    for (int i = 0; i < 20; i++) step();
    chk("t1_xfers", xfers, 16);
    chk("t1_lasts", lasts, 2);

    // backpressure
    for (int i = 16; i < 32; i++) push_word(i);
    for (int i = 0; i < 3; i++) step();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t2_stall_rd_en", fifo_rd_en, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("t2_xfers", xfers, 32);

    // flush with load
    m_ready = 1'b0;
    d0 = mdrop;
    for (int i = 0; i < 6; i++) push_word(32'h100 + i);
    for (int i = 0; i < 4; i++) step();
    flush_req = 1'b1; step(); flush_req = 1'b0;
    chk("t3_valid_off", m_valid, 0);
    for (int i = 0; i < 12; i++) step();
    chk("t3_drop", drop_cnt, d0 + 6);
    chk("t3_busy_low", flush_busy, 0);
    l0 = lasts;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(32'h200 + i);
    for (int i = 0; i < 12; i++) step();
    chk("t3_pos_restart", lasts, l0 + 1);

    // flush with a transfer in the same cycle
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'h300 + i);
    for (int i = 0; i < 4; i++) step();
    x0 = xfers; d0 = mdrop;
    m_ready = 1'b1; flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("t4_delivered", xfers, x0 + 1);
    for (int i = 0; i < 12; i++) step();
    chk("t4_drop", drop_cnt, d0 + 4);

    // reset mid-burst
    for (int i = 0; i < 10; i++) push_word(32'h400 + i);
    x0 = xfers;
    for (int i = 0; i < 20 && xfers - x0 < 4; i++) step();
    chk("t5_pre_xfers", xfers, x0 + 4);
    rd_reset = 1'b1; step(); step(); rd_reset = 1'b0;
    chk("t5_valid", m_valid, 0);
    chk("t5_data", m_data, 0);
    chk("t5_drop", drop_cnt, 0);
    l0 = lasts;
    pushed = 8 - fq.size();
    for (int i = 0; i < pushed; i++) push_word(32'h500 + i);
    for (int i = 0; i < 15; i++) step();
    chk("t5_pos0_last", lasts, l0 + 1);

    // realign burst position, then random backpressure
    flush_req = 1'b1; step(); flush_req = 1'b0;
    for (int i = 0; i < 8; i++) step();
    x0 = xfers; l0 = lasts; pushed = 0;
    for (int c = 0; c < 6000 && xfers - x0 < 1000; c++) begin
      if (pushed < 1000 && ($urandom % 4) != 0) begin
        push_word($urandom);
        pushed++;
      end
      m_ready = $urandom % 2;
      step();
    end
    chk("t6_xfers", xfers - x0, 1000);
    chk("t6_lasts", lasts - l0, 125);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
